multicycle_ctrl_unit: RTL and testbench
=======================================

Name: multicycle_ctrl_unit

Overview:
FSM controller that drives the RV32I datapath in multi-cycle mode. Fetch, decode, execute, memory and writeback each take their own cycle(s), and the datapath reaches instruction/data memory through req/ack handshakes that allow wait states. The block decodes the latched instruction word into the datapath's select/ALU controls and gates every architectural state update (IR, PC, register file, data memory) with per-state strobes.

Parameters:
TIMEOUT_CYCLES, 16, max cycles a memory request may wait for ack (used only with MCU_BUS_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst  in  1  reset
inst_code  in  32  latched instruction register contents
imem_req  out  1  instruction fetch request
imem_ack  in  1  fetch data valid / request accepted
dmem_req  out  1  data memory request
dmem_we  out  1  1 = store, 0 = load (valid while dmem_req)
dmem_ack  in  1  data access complete
mem_funct3  out  3  access size/sign = inst_code[14:12]
ir_write_en  out  1  load IR from fetch data
pc_write_en  out  1  commit next PC
reg_write_en  out  1  register file write strobe
alu_controls  out  4  ALU op; [2:0] doubles as branch condition
aluSrcMux_sel  out  1  0 = rs2, 1 = immediate
reg_write_data_sel  out  3  0 ALU, 1 mem data, 2 imm (LUI), 3 PC+imm (AUIPC), 4 PC+4
branch  out  1  branch instruction (qualified by ALU btaken)
JAL_sel  out  1  force PC = target (JAL and JALR)
JALR_sel  out  1  target base = rs1 instead of PC
halted  out  1  sticky; FSM in HALT
illegal_inst  out  1  sticky; HALT entered on an undecodable instruction
bus_error  out  1  sticky; HALT entered on timeout (0 without macro)

Behaviour:
- Reset is asynchronous and active-high (rst), clocked on clk. On reset: state = FETCH; all strobes, requests and sticky flags = 0.
- States: FETCH, DECODE, EXECUTE, MEM, WB, HALT. State encoding is one-hot.
- FETCH: imem_req=1, held until imem_ack is sampled high. A zero-wait-state ack (ack in the first req cycle) is legal. On ack: ir_write_en=1 for that cycle, then go to DECODE. An ack seen while req=0 is ignored.
- DECODE: inst_code is valid from this state on.
  - Unknown opcode, or branch funct3 010/011 -> HALT with illegal_inst=1.
  - SYSTEM opcode 1110011 -> HALT with illegal_inst=0.
  - Otherwise -> EXECUTE.
- EXECUTE:
  - B-type: branch=1 and pc_write_en=1, then FETCH.
  - Load/store: -> MEM.
  - All other instructions: -> WB.
- MEM: dmem_req=1, with dmem_we=1 for stores. Held until dmem_ack.
  - Store: pc_write_en=1 in the ack cycle, then FETCH.
  - Load: -> WB.
- WB: reg_write_en=1 and pc_write_en=1 in the same cycle, then FETCH. JAL/JALR also assert JAL_sel=1 in WB; JALR additionally asserts JALR_sel=1. PC+4 is written to rd from the pre-update PC.
- HALT: all strobes and requests are 0. Only rst exits this state.
- Decode outputs are combinational from inst_code in every state. Strobes are state-gated only.
  - alu_controls encoding: R-type = {inst[30], funct3}; OP-IMM = {inst[30] if funct3==101 else 0, funct3}; branch = {0, funct3}; load/store/JALR/AUIPC = ADD (0000).
  - aluSrcMux_sel=1 for OP-IMM, load and store.
- Invariants:
  - Exactly one pc_write_en per retired instruction.
  - Never two strobes of different stages in one cycle, except reg_write_en+pc_write_en in WB.
- Latency with zero-wait memory: branch 3 cycles; store 4; ALU/LUI/AUIPC/JAL/JALR 4; load 5.
- Reset mid-request drops imem_req/dmem_req asynchronously. The memory slave must tolerate an abandoned request.

Optional Feature:
MCU_BUS_TIMEOUT_EN
- Defined: a wait counter runs while imem_req or dmem_req is high and clears on ack or on leaving the state. When the counter reaches TIMEOUT_CYCLES without an ack: go to HALT, bus_error=1, requests dropped. An ack in the same cycle as the limit wins.
- Undefined: no counter; the FSM waits indefinitely and bus_error is tied to 0.

Decomposition:
- Package mcu_pkg holds:
  - state enum
  - opcode constants (R, OP-IMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR, SYSTEM)
  - alu_controls constants
  - reg_write_data_sel constants: WD_ALU, WD_MEM, WD_IMM, WD_AUIPC, WD_PC4
- Sub-module mcu_decoder: pure combinational inst_code -> select/ALU fields plus an illegal flag. The FSM lives in the top.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), immediate acks -> states F,D,E,WB. In cycle 4: reg_write_en=pc_write_en=1, alu_controls=0000, sel=0, aluSrc=0.
- LW x5,8(x1) (0x0080A283), dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0, mem_funct3=010; then WB with sel=1, aluSrc=1.
- BEQ x1,x2,+8 (0x00208463) -> branch=1 and pc_write_en=1 in EXECUTE. alu_controls[2:0]=000, no reg_write_en, next imem_req in cycle 4.
- JALR x1,0(x2) (0x000100E7) -> WB: JAL_sel=1, JALR_sel=1, sel=4, reg_write_en=pc_write_en=1.
- Fetch 0xFFFFFFFF -> HALT, illegal_inst=halted=1, no further imem_req for 20 cycles. Pulsing rst -> FETCH with flags cleared.
- rst asserted during MEM with dmem_req high -> dmem_req=0 immediately, FETCH after release. With MCU_BUS_TIMEOUT_EN and no imem_ack for 16 cycles -> HALT, bus_error=1.

Source files
------------

// File: rtl/mcu_pkg.sv
// Shared types and constants for the multi-cycle RV32I control unit.
package mcu_pkg;

  typedef enum logic [5:0] {
    S_FETCH   = 6'b000001,
    S_DECODE  = 6'b000010,
    S_EXECUTE = 6'b000100,
    S_MEM     = 6'b001000,
    S_WB      = 6'b010000,
    S_HALT    = 6'b100000
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  localparam logic [2:0] WD_ALU   = 3'd0;
  localparam logic [2:0] WD_MEM   = 3'd1;
  localparam logic [2:0] WD_IMM   = 3'd2;
  localparam logic [2:0] WD_AUIPC = 3'd3;
  localparam logic [2:0] WD_PC4   = 3'd4;

  typedef struct packed {
    logic [3:0] alu;
    logic       alu_src;
    logic [2:0] wd_sel;
    logic       is_branch;
    logic       is_load;
    logic       is_store;
    logic       is_jal;     // JAL or JALR: PC forced to target
    logic       is_jalr;
    logic       is_system;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/mcu_decoder.sv
// Combinational instruction decode: datapath selects, ALU op and class flags.
module mcu_decoder
  import mcu_pkg::*;
(
  input  logic [31:0] inst_code,
  output dec_t        dec
);

  logic [6:0] op;
  logic [2:0] f3;
  logic       unused_bits;

  assign op = inst_code[6:0];
  assign f3 = inst_code[14:12];
  assign unused_bits = ^{inst_code[31], inst_code[29:15], inst_code[11:7]};

  always_comb begin
    dec        = '0;
    dec.alu    = ALU_ADD;
    dec.wd_sel = WD_ALU;
    case (op)
      OP_R:      dec.alu = {inst_code[30], f3};
      OP_IMM: begin
        // only SRAI/SRLI use bit 30; elsewhere it is immediate data
        dec.alu     = {(f3 == 3'b101) & inst_code[30], f3};
        dec.alu_src = 1'b1;
      end
      OP_LOAD: begin
        dec.is_load = 1'b1;
        dec.alu_src = 1'b1;
        dec.wd_sel  = WD_MEM;
      end
      OP_STORE: begin
        dec.is_store = 1'b1;
        dec.alu_src  = 1'b1;
      end
      OP_BRANCH: begin
        dec.is_branch = 1'b1;
        dec.alu       = {1'b0, f3};
        dec.illegal   = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OP_LUI:    dec.wd_sel = WD_IMM;
      OP_AUIPC:  dec.wd_sel = WD_AUIPC;
      OP_JAL: begin
        dec.is_jal = 1'b1;
        dec.wd_sel = WD_PC4;
      end
      OP_JALR: begin
        dec.is_jal  = 1'b1;
        dec.is_jalr = 1'b1;
        dec.wd_sel  = WD_PC4;
      end
      OP_SYSTEM: dec.is_system = 1'b1;
      default:   dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_unit.sv
// Multi-cycle RV32I controller: FETCH/DECODE/EXECUTE/MEM/WB/HALT sequencing.
// Optional bus wait timeout enabled by defining MCU_BUS_TIMEOUT_EN.
module multicycle_ctrl_unit
  import mcu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_code,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic [2:0]  mem_funct3,
  output logic        ir_write_en,
  output logic        pc_write_en,
  output logic        reg_write_en,
  output logic [3:0]  alu_controls,
  output logic        aluSrcMux_sel,
  output logic [2:0]  reg_write_data_sel,
  output logic        branch,
  output logic        JAL_sel,
  output logic        JALR_sel,
  output logic        halted,
  output logic        illegal_inst,
  output logic        bus_error
);

  state_t state;
  dec_t   dec;
  logic   illegal_q, bus_err_q, timeout;
  logic   in_exec, in_mem, in_wb;

  mcu_decoder u_dec (.inst_code(inst_code), .dec(dec));

  assign in_exec = (state == S_EXECUTE);
  assign in_mem  = (state == S_MEM);
  assign in_wb   = (state == S_WB);

  // reset state is FETCH, so the fetch request is masked while rst is high
  assign imem_req = (state == S_FETCH) & ~rst;
  assign dmem_req = in_mem;
  assign dmem_we  = in_mem & dec.is_store;

  assign ir_write_en  = imem_req & imem_ack;
  assign pc_write_en  = (in_exec & dec.is_branch) | (dmem_req & dmem_ack & dec.is_store) | in_wb;
  assign reg_write_en = in_wb;
  assign branch       = in_exec & dec.is_branch;
  assign JAL_sel      = in_wb & dec.is_jal;
  assign JALR_sel     = in_wb & dec.is_jalr;

  assign mem_funct3         = inst_code[14:12];
  assign alu_controls       = dec.alu;
  assign aluSrcMux_sel      = dec.alu_src;
  assign reg_write_data_sel = dec.wd_sel;
  assign halted             = (state == S_HALT);
  assign illegal_inst       = illegal_q;
  assign bus_error          = bus_err_q;

`ifdef MCU_BUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;
  logic          waiting;

  // an ack in the limit cycle wins because waiting excludes it
  assign waiting = (imem_req & ~imem_ack) | (dmem_req & ~dmem_ack);
  assign timeout = waiting & (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     wait_cnt <= '0;
    else if (waiting & ~timeout) wait_cnt <= wait_cnt + 1'b1;
    else                         wait_cnt <= '0;
  end
`else
  logic unused_timeout;
  assign timeout        = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_FETCH;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      case (state)
        S_FETCH:
          if (imem_ack) state <= S_DECODE;
          else if (timeout) begin
            state     <= S_HALT;
            bus_err_q <= 1'b1;
          end
        S_DECODE:
          if (dec.illegal) begin
            state     <= S_HALT;
            illegal_q <= 1'b1;
          end else if (dec.is_system) state <= S_HALT;
          else                        state <= S_EXECUTE;
        S_EXECUTE:
          if (dec.is_branch)                   state <= S_FETCH;
          else if (dec.is_load | dec.is_store) state <= S_MEM;
          else                                 state <= S_WB;
        S_MEM:
          if (dmem_ack) state <= dec.is_store ? S_FETCH : S_WB;
          else if (timeout) begin
            state     <= S_HALT;
            bus_err_q <= 1'b1;
          end
        S_WB:    state <= S_FETCH;
        S_HALT:  state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_unit.sv
// Self-checking bench for multicycle_ctrl_unit: vector table + scoreboard, plus halt/reset corner cases.
module tb_multicycle_ctrl_unit;

  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] inst_code = '0;
  logic        imem_ack = 1'b0, dmem_ack = 1'b0;
  logic        imem_req, dmem_req, dmem_we, ir_write_en, pc_write_en, reg_write_en;
  logic [2:0]  mem_funct3, reg_write_data_sel;
  logic [3:0]  alu_controls;
  logic        aluSrcMux_sel, branch, JAL_sel, JALR_sel, halted, illegal_inst, bus_error;

  int tests = 0, fails = 0;

  multicycle_ctrl_unit dut (
    .clk(clk), .rst(rst), .inst_code(inst_code),
    .imem_req(imem_req), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .mem_funct3(mem_funct3), .ir_write_en(ir_write_en), .pc_write_en(pc_write_en),
    .reg_write_en(reg_write_en), .alu_controls(alu_controls), .aluSrcMux_sel(aluSrcMux_sel),
    .reg_write_data_sel(reg_write_data_sel), .branch(branch), .JAL_sel(JAL_sel),
    .JALR_sel(JALR_sel), .halted(halted), .illegal_inst(illegal_inst), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    int          iw, dw, lat;
    logic [3:0]  alu;
    bit          chk_alu;
    logic [2:0]  sel;
    bit          chk_sel;
    bit          src, rwe, br, jal, jalr, dwe;
    int          dreq;
    logic [2:0]  f3;
  } vec_t;

  vec_t vecs[15];
  vec_t sb[$];

  function automatic vec_t mk(logic [31:0] inst, int iw, int dw, int lat, logic [3:0] alu, bit ca,
                              logic [2:0] sel, bit cs, bit src, bit rwe, bit br, bit jal, bit jalr,
                              bit dwe, int dreq, logic [2:0] f3);
    vec_t v;
    v.inst = inst; v.iw = iw; v.dw = dw; v.lat = lat; v.alu = alu; v.chk_alu = ca;
    v.sel = sel; v.chk_sel = cs; v.src = src; v.rwe = rwe; v.br = br; v.jal = jal;
    v.jalr = jalr; v.dwe = dwe; v.dreq = dreq; v.f3 = f3;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  // Run one instruction from a FETCH-entry negedge until its PC commit.
  task automatic run_vec(input int idx, input vec_t v);
    int cyc = 0, ireq_n = 0, dreq_n = 0, pcw = 0, rw = 0, irw = 0, conflicts = 0;
    bit done = 0, dwe_seen = 0;
    logic [3:0] alu_o = '0;
    logic [2:0] sel_o = '0, f3_o = '0;
    bit src_o = 0, br_o = 0, jal_o = 0, jalr_o = 0;
    vec_t e;
    inst_code = v.inst;
    sb.push_back(v);
    while (!done && cyc < 60) begin
      #1;
      imem_ack = imem_req && (ireq_n == v.iw);
      dmem_ack = dmem_req && (dreq_n == v.dw);
      #1;
      if (cyc == 0) chk("fetch_start", idx, int'(imem_req), 1);
      cyc++;
      if (imem_req) ireq_n++;
      if (dmem_req) begin
        dreq_n++;
        if (dmem_we) dwe_seen = 1;
        f3_o = mem_funct3;
      end
      if (ir_write_en) irw++;
      if (reg_write_en) rw++;
      if ((ir_write_en && (pc_write_en || reg_write_en)) || (reg_write_en && !pc_write_en) ||
          (imem_req && dmem_req)) conflicts++;
      if (pc_write_en) begin
        pcw++; done = 1;
        alu_o = alu_controls; sel_o = reg_write_data_sel; src_o = aluSrcMux_sel;
        br_o = branch; jal_o = JAL_sel; jalr_o = JALR_sel;
      end
      @(negedge clk);
    end
    imem_ack = 0; dmem_ack = 0;
    e = sb.pop_front();
    chk("latency", idx, cyc, e.lat);
    chk("pc_writes", idx, pcw, 1);
    chk("ir_writes", idx, irw, 1);
    chk("reg_writes", idx, rw, int'(e.rwe));
    chk("strobe_conflicts", idx, conflicts, 0);
    chk("alu_src", idx, int'(src_o), int'(e.src));
    chk("branch", idx, int'(br_o), int'(e.br));
    chk("jal_sel", idx, int'(jal_o), int'(e.jal));
    chk("jalr_sel", idx, int'(jalr_o), int'(e.jalr));
    chk("dmem_req_cycles", idx, dreq_n, e.dreq);
    chk("dmem_we", idx, int'(dwe_seen), int'(e.dwe));
    if (e.chk_alu) chk("alu_controls", idx, int'(alu_o), int'(e.alu));
    if (e.chk_sel) chk("wd_sel", idx, int'(sel_o), int'(e.sel));
    if (e.dreq > 0) chk("mem_funct3", idx, int'(f3_o), int'(e.f3));
  endtask

  // Fetch an instruction that must halt; check stickiness, silence, then recover via rst.
  task automatic run_halt(input int idx, input logic [31:0] inst, input bit exp_ill);
    int act = 0;
    inst_code = inst;
    #1 imem_ack = 1;
    @(negedge clk); #1 imem_ack = 0;
    @(negedge clk); #1;
    chk("halted", idx, int'(halted), 1);
    chk("illegal_inst", idx, int'(illegal_inst), int'(exp_ill));
    imem_ack = 1;  // acks without a request must be ignored
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (imem_req || dmem_req || ir_write_en || pc_write_en || reg_write_en || !halted) act++;
    end
    imem_ack = 0;
    chk("halt_quiet", idx, act, 0);
    rst = 1; #1;
    chk("halt_rst_flags", idx, int'({halted, illegal_inst, bus_error, imem_req}), 0);
    @(negedge clk); rst = 0; #1;
    chk("halt_rst_fetch", idx, int'(imem_req), 1);
    @(negedge clk);
  endtask

  initial begin
    int n;
    vecs[0]  = mk(32'h002081B3, 0, 0, 4, 4'b0000, 1, 3'd0, 1, 0, 1, 0, 0, 0, 0, 0, 3'd0); // ADD
    vecs[1]  = mk(32'h402081B3, 0, 0, 4, 4'b1000, 1, 3'd0, 1, 0, 1, 0, 0, 0, 0, 0, 3'd0); // SUB
    vecs[2]  = mk(32'h0080A283, 0, 3, 8, 4'b0000, 1, 3'd1, 1, 1, 1, 0, 0, 0, 0, 4, 3'd2); // LW, 3 waits
    vecs[3]  = mk(32'h0050A423, 0, 1, 5, 4'b0000, 1, 3'd0, 0, 1, 0, 0, 0, 0, 1, 2, 3'd2); // SW, 1 wait
    vecs[4]  = mk(32'h00208463, 2, 0, 5, 4'b0000, 1, 3'd0, 0, 0, 0, 1, 0, 0, 0, 0, 3'd0); // BEQ, 2 fetch waits
    vecs[5]  = mk(32'h00209463, 0, 0, 3, 4'b0001, 1, 3'd0, 0, 0, 0, 1, 0, 0, 0, 0, 3'd0); // BNE
    vecs[6]  = mk(32'h000100E7, 0, 0, 4, 4'b0000, 1, 3'd4, 1, 0, 1, 0, 1, 1, 0, 0, 3'd0); // JALR
    vecs[7]  = mk(32'h008000EF, 0, 0, 4, 4'b0000, 0, 3'd4, 1, 0, 1, 0, 1, 0, 0, 0, 3'd0); // JAL
    vecs[8]  = mk(32'h123452B7, 0, 0, 4, 4'b0000, 0, 3'd2, 1, 0, 1, 0, 0, 0, 0, 0, 3'd0); // LUI
    vecs[9]  = mk(32'h00001297, 0, 0, 4, 4'b0000, 1, 3'd3, 1, 0, 1, 0, 0, 0, 0, 0, 3'd0); // AUIPC
    vecs[10] = mk(32'h4030D293, 0, 0, 4, 4'b1101, 1, 3'd0, 1, 1, 1, 0, 0, 0, 0, 0, 3'd0); // SRAI
    vecs[11] = mk(32'hC0008293, 0, 0, 4, 4'b0000, 1, 3'd0, 1, 1, 1, 0, 0, 0, 0, 0, 3'd0); // ADDI, imm bit30 set
    vecs[12] = mk(32'h002081B3, 3, 0, 7, 4'b0000, 1, 3'd0, 1, 0, 1, 0, 0, 0, 0, 0, 3'd0); // ADD, 3 fetch waits
    vecs[13] = mk(32'h00008283, 0, 0, 5, 4'b0000, 1, 3'd1, 1, 1, 1, 0, 0, 0, 0, 1, 3'd0); // LB
    vecs[14] = mk(32'h00509023, 0, 0, 4, 4'b0000, 1, 3'd0, 0, 1, 0, 0, 0, 0, 1, 1, 3'd1); // SH

    @(negedge clk); #1;
    chk("reset_outputs", 0, int'({imem_req, dmem_req, ir_write_en, pc_write_en, reg_write_en,
                                  halted, illegal_inst, bus_error}), 0);
    @(negedge clk); rst = 0;

    for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

    run_halt(0, 32'hFFFFFFFF, 1);  // unknown opcode
    run_halt(1, 32'h00000073, 0);  // ECALL
    run_halt(2, 32'h0020A463, 1);  // branch funct3 010

    // reset while a load waits in MEM
    inst_code = 32'h0080A283;
    #1 imem_ack = 1;
    @(negedge clk); #1 imem_ack = 0;
    n = 0;
    while (!dmem_req && n < 10) begin @(negedge clk); #1; n++; end
    chk("reach_mem", 0, int'(dmem_req), 1);
    rst = 1; #1;
    chk("rst_drops_dmem_req", 0, int'({dmem_req, imem_req}), 0);
    @(negedge clk); rst = 0;
    run_vec(15, vecs[0]);

`ifdef MCU_BUS_TIMEOUT_EN
    inst_code = 32'h002081B3;
    n = 0;
    #1;
    while (!halted && n < 40) begin
      if (imem_req) n++;
      @(negedge clk); #1;
    end
    chk("timeout_req_cycles", 0, n, 16);
    chk("timeout_bus_error", 0, int'({halted, bus_error, imem_req}), 6);
    rst = 1; @(negedge clk); rst = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
